// File: rtl/expr_sig_compactor.sv
// Folds each accepted 90-bit expression result into a 32-bit MISR signature and
// compares it against golden_sig after NVEC vectors. Optional: EXPR_SIG_PARITY_EN.
module expr_sig_compactor #(
  parameter int unsigned NVEC = 256,
  parameter logic [31:0] POLY = 32'h04C11DB7,
  parameter logic [31:0] SEED = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        y_valid,
  output logic        y_ready,
  input  logic [89:0] y,
  input  logic [31:0] golden_sig,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] sig,
  output logic [15:0] vec_cnt,
  output logic [17:0] field_par
);

  localparam logic [15:0] LAST_CNT = 16'(NVEC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] sig_q, sig_d;
  logic [15:0] cnt_q, cnt_d;
  logic        pass_q, pass_d;
  logic        xfer;
  logic [31:0] fold;

  // Ready depends on state only, so the upstream valid can never loop back into it.
  assign y_ready = (state_q == S_RUN);
  assign xfer    = y_valid && y_ready;
  assign fold    = y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          sig_d   = SEED;
          cnt_d   = '0;
          pass_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (xfer) begin
          sig_d = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? POLY : 32'h0) ^ fold;
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == LAST_CNT) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        pass_d  = (sig_q == golden_sig);
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  end

  assign busy    = (state_q == S_RUN) || (state_q == S_CHECK);
  assign done    = (state_q == S_DONE);
  assign pass    = pass_q;
  assign sig     = sig_q;
  assign vec_cnt = cnt_q;

`ifdef EXPR_SIG_PARITY_EN
  // LSB position of field idx; fields are packed from the MSB with widths 4,5,6,...
  function automatic int fld_lsb(input int idx);
    int pos;
    pos = 90;
    for (int k = 0; k <= idx; k++) pos -= 4 + (k % 3);
    return pos;
  endfunction

  logic [17:0] fpar;
  logic [17:0] par_q, par_d;
  logic        par_clr;

  for (genvar i = 0; i < 18; i++) begin : g_fld
    localparam int W = 4 + (i % 3);
    localparam int L = fld_lsb(i);
    assign fpar[17-i] = ^y[L +: W];
  end

  assign par_clr = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    par_d = par_q;
    if (par_clr)   par_d = '0;
    else if (xfer) par_d = par_q ^ fpar;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= '0;
    else        par_q <= par_d;
  end

  assign field_par = par_q;
`else
  assign field_par = '0;
`endif

endmodule

// File: doc/expr_sig_compactor.md
# expr_sig_compactor

Downstream checker for the generated expression blocks. It consumes the 90-bit packed result bus `y` over a valid/ready handshake and folds each accepted vector into a 32-bit CRC-style signature (MISR). After a configured number of vectors it compares the signature against a golden value and reports pass or fail. It sits between the expression DUT's `y` output and the regression scoreboard, so thousands of vectors reduce to a single compare.

## Interface
Parameters:
- `NVEC`, 256: vectors to accept per run; legal range 1..65535.
- `POLY`, 32'h04C11DB7: feedback polynomial.
- `SEED`, 32'hFFFFFFFF: signature value loaded on `start`.

Ports:
- `clk`  in  1  single clock; all state is on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  one-cycle pulse that begins a run.
- `y_valid`  in  1  the result vector is valid.
- `y_ready`  out  1  the block accepts a vector.
- `y`  in  90  packed result. Fields from the MSB down are `y0..y17`, with widths 4,5,6,4,5,6 repeated three times.
- `golden_sig`  in  32  expected signature; sampled in CHECK.
- `busy`  out  1  high in RUN and CHECK.
- `done`  out  1  high in DONE.
- `pass`  out  1  compare result; valid while `done` is high.
- `sig`  out  32  current signature.
- `vec_cnt`  out  16  number of vectors accepted this run.
- `field_par`  out  18  per-field accumulated parity. Bit 17 is `y0` and bit 0 is `y17`.

## Operation
- States: IDLE, RUN, CHECK, DONE.
  - IDLE: on `start`, go to RUN with `sig`=SEED, `vec_cnt`=0, `field_par`=0, `pass`=0.
  - RUN: `y_ready`=1. A transfer occurs when `y_valid`&&`y_ready`.
  - On a transfer where `vec_cnt`==NVEC-1, the counter still increments and the state goes to CHECK.
  - CHECK: `y_ready`=0. Register `pass` = (`sig`==`golden_sig`) and go to DONE.
  - DONE: hold all outputs. On `start`, re-initialise exactly as from IDLE and go to RUN.
- Signature update on each transfer:
  - fold = `y[31:0]` ^ `y[63:32]` ^ {6'b0, `y[89:64]`}
  - `sig` <= (`sig`<<1) ^ (`sig[31]` ? POLY : 0) ^ fold
  - All arithmetic is unsigned and truncated to 32 bits.
- `vec_cnt` increments by 1 per transfer with 16-bit width. It never wraps, because NVEC ≤ 65535.
- `start` is ignored in RUN and CHECK.
- `y_valid` is ignored whenever `y_ready`=0. Data presented while not ready is neither consumed nor counted.
- `y_ready` is combinational from the state only. It never depends on `y_valid`.

## Timing
- Reset values: state IDLE, `y_ready`=0, `busy`=0, `done`=0, `pass`=0, `sig`=SEED, `vec_cnt`=0, `field_par`=0.
- Reset asserted mid-run aborts immediately (asynchronous). Nothing is retained.
- `start` at edge t gives `y_ready`=1 after edge t. The first transfer can occur at edge t+1.
- `sig` and `vec_cnt` reflect a transfer in the cycle after its edge, i.e. one cycle of latency.
- If the last transfer is at edge k, CHECK occupies the cycle after k, and `done`/`pass` are visible after edge k+1.
- `golden_sig` must be stable during the CHECK cycle.
- Throughput is one vector per cycle in RUN. Gaps in `y_valid` are allowed and do not alter the signature.

## Configuration
- `EXPR_SIG_PARITY_EN` defined:
  - On each transfer, `field_par[i]` ^= XOR-reduce of its field.
  - This gives the location of a signature mismatch per output field.
- Not defined: `field_par` is tied to 0 and its registers are removed. Signature behaviour is unchanged.

## Test plan
- Reset then idle:
  - Hold `rst_n`=0, release it, and keep `start` low for 10 cycles.
  - Required: `y_ready`=0, `busy`=0, `done`=0, `sig`=32'hFFFFFFFF.
- Single vector (NVEC=1):
  - Pulse `start`, then send `y`=0 with `golden_sig`=32'hFB3EE249.
  - Required: `sig`=32'hFB3EE249, `vec_cnt`=1, `done`=1 two cycles after the transfer, `pass`=1.
- Fail path:
  - Same stimulus with `golden_sig`=0.
  - Required: `done`=1, `pass`=0.
- Backpressure and gaps (NVEC=4):
  - Toggle `y_valid` 1,0,1,0,... with vectors 1,2,3,4.
  - Required: `vec_cnt`=4 and `sig` equal to the software model with the gaps ignored.
  - Extra `y_valid` pulses during CHECK/DONE are not counted.
- Reset mid-run:
  - NVEC=8; drop `rst_n` after 3 transfers.
  - Required: immediate return to IDLE with `vec_cnt`=0 and `sig`=SEED.
  - Pulsing `start` during RUN has no effect.
- Parity (`EXPR_SIG_PARITY_EN` defined, NVEC=2):
  - Send `y`={4'b0001, 86'b0} twice.
  - Required: after the first transfer `field_par`=18'h20000; after the second `field_par`=0.
  - Undefined build: `field_par` stays 0.
